spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, transmit byte width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, the done-watchdog limit (used only under REQ-030).
REQ-004 SHALL have port clk  input  1  system clock; reset rst, synchronous, active-high; clock clk.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester transfer request, level, held until ack.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_W  per-requester byte, slice i = requester i.
REQ-008 SHALL have port req_ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port req_err  output  NUM_REQ  one-cycle timeout pulse; tied 0 when REQ-030 is off.
REQ-010 SHALL have port m_start  output  1  one-cycle start pulse to the shared SPI master.
REQ-011 SHALL have port m_data  output  DATA_W  byte to the SPI master, MSB first on the wire.
REQ-012 SHALL have port m_done  input  1  one-cycle completion pulse from the SPI master.
REQ-013 SHALL have port m_sel  output  NUM_REQ  one-hot slave-select decode for per-slave cs gating.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, START, WAIT, ACK; all outputs SHALL be registered.
REQ-016 IDLE: if any req bit is high, register grant = first set bit searching upward from last_grant+1 (mod NUM_REQ), capture that requester's slice into m_data, and go to START.
REQ-017 START: drive m_start=1 for exactly one cycle, then go to WAIT. m_start therefore rises in the cycle after req is first sampled high.
REQ-018 WAIT: hold m_data and m_sel stable. On m_done=1, go to ACK.
REQ-019 ACK: pulse req_ack[grant] for one cycle, set last_grant=grant, and return to IDLE. A new grant is therefore possible two cycles after m_done.
REQ-020 m_sel SHALL be one-hot at the grant index in START, WAIT and ACK, and all-zero in IDLE.
REQ-021 m_done SHALL be ignored in IDLE, START and ACK, including when it coincides with m_start.
REQ-022 Deasserting req[grant] after grant SHALL NOT abort the transfer; ack is still pulsed.
REQ-023 A requester holding req through ack SHALL re-enter arbitration at lowest priority (round-robin fairness).
REQ-024 Simultaneous requests SHALL be served in rotating order; no requester waits more than NUM_REQ-1 transfers.
REQ-025 Changes to req_data after capture SHALL NOT affect m_data.

Reset
REQ-026 On rst, the state SHALL go to IDLE, and m_start, req_ack, req_err, m_sel and busy SHALL be 0.
REQ-027 On rst, m_data SHALL be 0 and last_grant SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-028 rst mid-transfer SHALL abort with no ack or err pulse; a stale m_done after reset is ignored per REQ-021.
REQ-029 rst SHALL take precedence over every other event in the same cycle.

Configuration
REQ-030 Macro SPI_ARBITER_TIMEOUT_EN, when defined, SHALL add a WAIT-state cycle counter:
- if TIMEOUT_CYCLES cycles elapse without m_done, pulse req_err[grant] (no ack), update last_grant, and return to IDLE;
- m_done arriving in the same cycle as expiry wins and produces an ack;
- the counter is cleared on entering WAIT.
REQ-031 Without the macro, WAIT SHALL wait indefinitely, req_err SHALL be constant 0, and no counter logic SHALL exist.

Structure
REQ-032 Package spi_pkg SHALL hold the state enum type (arb_state_t) and the default NUM_REQ/DATA_W constants.
REQ-033 Sub-module spi_rr_arbiter (combinational round-robin priority pick: req, last_grant -> grant index, valid) SHALL be instantiated once.

Verification
REQ-034 Single request: req=4'b0010, slice1=8'hA3 -> m_start one cycle later, m_data=8'hA3, m_sel=4'b0010; m_done -> req_ack=4'b0010 two cycles after m_done.
REQ-035 Contention: req=4'b1111 held, m_done returned 4 cycles after each m_start -> grants in order 0,1,2,3,0.
REQ-036 Stale done: m_done pulsed in IDLE and in START -> no state change, no ack.
REQ-037 Mid-transfer reset: rst pulsed in WAIT -> next cycle busy=0, m_sel=0, no ack; the next grant after reset goes to requester 0.
REQ-038 With SPI_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, m_done withheld -> req_err[grant] pulses after 16 WAIT cycles, then IDLE.
REQ-039 Data hold: req_data changed during WAIT -> m_data unchanged until ACK.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: arbiter state type (arb_state_t) and default NUM_REQ/DATA_W sizes shared by the SPI arbiter files
package spi_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} arb_state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester + SPI master bus; slave modport = arbiter side (req/req_data/m_done in; req_ack/req_err/m_start/m_data/m_sel/busy out), master modport = driver side
interface spi_arbiter_if import spi_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W = DEF_DATA_W
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0] req_ack;
  logic [NUM_REQ-1:0] req_err;
  logic m_start;
  logic [DATA_W-1:0] m_data;
  logic m_done;
  logic [NUM_REQ-1:0] m_sel;
  logic busy;
  modport slave (input req, req_data, m_done, output req_ack, req_err, m_start, m_data, m_sel, busy);
  modport master (output req, req_data, m_done, input req_ack, req_err, m_start, m_data, m_sel, busy);
endinterface

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: combinational round-robin pick (in: req, last_grant; out: grant index, valid), searching upward from last_grant+1
module spi_rr_arbiter import spi_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       valid
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] idx;
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one SPI master among NUM_REQ requesters (ports: clk, rst, bus = spi_arbiter_if.slave); define SPI_ARBITER_TIMEOUT_EN for the TIMEOUT_CYCLES done-watchdog
module spi_arbiter import spi_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic clk,
  input logic rst,
  spi_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_t state, state_n;
  logic [IW-1:0] grant, grant_n, last_grant, pick;
  logic pick_valid, expire;
  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req(bus.req),
    .last_grant(last_grant),
    .grant(pick),
    .valid(pick_valid)
  );
  always_comb begin
    state_n = state == IDLE  ? (pick_valid ? START : IDLE)
            : state == START ? WAIT
            : state == WAIT  ? (bus.m_done ? ACK : expire ? IDLE : WAIT)
            : IDLE;
    grant_n = (state == IDLE && pick_valid) ? pick : grant;
  end
  // outputs are registered from next-state so m_sel/busy/m_start line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      bus.m_data <= '0;
      bus.m_start <= 1'b0;
      bus.m_sel <= '0;
      bus.busy <= 1'b0;
      bus.req_ack <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      if (state == IDLE && pick_valid) bus.m_data <= DATA_W'(bus.req_data >> (DATA_W * int'(pick)));
      bus.m_start <= state_n == START;
      bus.m_sel <= (state_n == IDLE) ? '0 : (NUM_REQ'(1) << grant_n);
      bus.busy <= state_n != IDLE;
      bus.req_ack <= (state == ACK) ? (NUM_REQ'(1) << grant) : '0;
      if (state == ACK || expire) last_grant <= grant;
    end
  end
`ifdef SPI_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  // counter is held at zero outside WAIT, so it restarts on every WAIT entry
  always_ff @(posedge clk) begin
    cnt <= (rst || state != WAIT) ? '0 : cnt + 1'b1;
    bus.req_err <= (!rst && expire) ? (NUM_REQ'(1) << grant) : '0;
  end
  assign expire = state == WAIT && !bus.m_done && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign expire = 1'b0;
  assign bus.req_err = '0;
`endif
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: table-driven and directed-sequence checks of spi_arbiter
module tb_spi_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus();
  spi_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        done;
    logic        start;
    logic [3:0]  sel;
    logic [7:0]  mdata;
    logic [3:0]  ack;
    logic        busy;
  } vec_t;
  vec_t vecs[19];
  localparam logic [31:0] D1 = 32'h0000_A300;
  localparam logic [31:0] D2 = 32'h0000_5500;
  localparam logic [31:0] DR = 32'h7766_5544;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic check_outs(input string tag, input logic start, input logic [3:0] sel,
                            input logic [7:0] md, input logic [3:0] ack, input logic busy);
    chk({tag, ".m_start"}, 32'(bus.m_start), 32'(start));
    chk({tag, ".m_sel"}, 32'(bus.m_sel), 32'(sel));
    chk({tag, ".m_data"}, 32'(bus.m_data), 32'(md));
    chk({tag, ".req_ack"}, 32'(bus.req_ack), 32'(ack));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
    chk({tag, ".req_err"}, 32'(bus.req_err), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    int t;
    logic [3:0] g1;
    bus.req = '0;
    bus.req_data = '0;
    bus.m_done = 1'b0;
    vecs[0]  = '{1'b1, 4'b0000, D1, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0};
    vecs[1]  = '{1'b0, 4'b0010, D1, 1'b0, 1'b1, 4'b0010, 8'hA3, 4'b0000, 1'b1};
    vecs[2]  = '{1'b0, 4'b0010, D1, 1'b1, 1'b0, 4'b0010, 8'hA3, 4'b0000, 1'b1};
    vecs[3]  = '{1'b0, 4'b0010, D2, 1'b0, 1'b0, 4'b0010, 8'hA3, 4'b0000, 1'b1};
    vecs[4]  = '{1'b0, 4'b0000, D2, 1'b0, 1'b0, 4'b0010, 8'hA3, 4'b0000, 1'b1};
    vecs[5]  = '{1'b0, 4'b0000, D2, 1'b1, 1'b0, 4'b0010, 8'hA3, 4'b0000, 1'b1};
    vecs[6]  = '{1'b0, 4'b0000, D2, 1'b0, 1'b0, 4'b0000, 8'hA3, 4'b0010, 1'b0};
    vecs[7]  = '{1'b0, 4'b0000, D2, 1'b1, 1'b0, 4'b0000, 8'hA3, 4'b0000, 1'b0};
    vecs[8]  = '{1'b0, 4'b0100, DR, 1'b0, 1'b1, 4'b0100, 8'h66, 4'b0000, 1'b1};
    vecs[9]  = '{1'b0, 4'b0100, DR, 1'b0, 1'b0, 4'b0100, 8'h66, 4'b0000, 1'b1};
    vecs[10] = '{1'b1, 4'b0100, DR, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0};
    vecs[11] = '{1'b0, 4'b0000, DR, 1'b1, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0};
    vecs[12] = '{1'b0, 4'b1101, DR, 1'b0, 1'b1, 4'b0001, 8'h44, 4'b0000, 1'b1};
    vecs[13] = '{1'b0, 4'b0001, DR, 1'b0, 1'b0, 4'b0001, 8'h44, 4'b0000, 1'b1};
    vecs[14] = '{1'b0, 4'b0001, DR, 1'b1, 1'b0, 4'b0001, 8'h44, 4'b0000, 1'b1};
    vecs[15] = '{1'b0, 4'b0001, DR, 1'b0, 1'b0, 4'b0000, 8'h44, 4'b0001, 1'b0};
    vecs[16] = '{1'b0, 4'b0000, DR, 1'b0, 1'b0, 4'b0000, 8'h44, 4'b0000, 1'b0};
    vecs[17] = '{1'b0, 4'b1100, DR, 1'b0, 1'b1, 4'b0100, 8'h66, 4'b0000, 1'b1};
    vecs[18] = '{1'b1, 4'b0000, DR, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0};
    tick;
    for (int i = 0; i < 19; i++) begin
      rst = vecs[i].rst;
      bus.req = vecs[i].req;
      bus.req_data = vecs[i].data;
      bus.m_done = vecs[i].done;
      tick;
      check_outs($sformatf("vec%0d", i), vecs[i].start, vecs[i].sel, vecs[i].mdata, vecs[i].ack, vecs[i].busy);
    end
    rst = 1'b0;
    bus.req = 4'b1111;
    bus.req_data = 32'h4433_2211;
    bus.m_done = 1'b0;
    for (int gi = 0; gi < 5; gi++) begin
      g1 = 4'b0001 << (gi % 4);
      t = 0;
      do begin tick; t++; end while (!bus.m_start && t < 8);
      chk($sformatf("cont%0d.start_seen", gi), 32'(bus.m_start), 32'd1);
      chk($sformatf("cont%0d.m_sel", gi), 32'(bus.m_sel), 32'(g1));
      chk($sformatf("cont%0d.m_data", gi), 32'(bus.m_data), 32'(8'h11 * ((gi % 4) + 1)));
      repeat (3) tick;
      bus.m_done = 1'b1;
      tick;
      bus.m_done = 1'b0;
      t = 0;
      do begin tick; t++; end while (bus.req_ack == '0 && t < 8);
      chk($sformatf("cont%0d.req_ack", gi), 32'(bus.req_ack), 32'(g1));
    end
    bus.req = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
`ifdef SPI_ARBITER_TIMEOUT_EN
    bus.req = 4'b0001;
    tick;
    chk("to.m_start", 32'(bus.m_start), 32'd1);
    bus.req = '0;
    tick;
    repeat (15) tick;
    chk("to.busy_w16", 32'(bus.busy), 32'd1);
    chk("to.err_w16", 32'(bus.req_err), 32'd0);
    tick;
    chk("to.req_err", 32'(bus.req_err), 32'b0001);
    chk("to.no_ack", 32'(bus.req_ack), 32'd0);
    chk("to.idle", 32'(bus.busy), 32'd0);
    tick;
    chk("to.err_pulse", 32'(bus.req_err), 32'd0);
    bus.req = 4'b0001;
    tick;
    bus.req = '0;
    tick;
    repeat (15) tick;
    bus.m_done = 1'b1;
    tick;
    bus.m_done = 1'b0;
    chk("tie.busy", 32'(bus.busy), 32'd1);
    chk("tie.no_err", 32'(bus.req_err), 32'd0);
    tick;
    chk("tie.req_ack", 32'(bus.req_ack), 32'b0001);
    chk("tie.err_after", 32'(bus.req_err), 32'd0);
`else
    bus.req = 4'b0001;
    tick;
    chk("hold.m_start", 32'(bus.m_start), 32'd1);
    bus.req = '0;
    repeat (40) tick;
    chk("hold.busy", 32'(bus.busy), 32'd1);
    chk("hold.no_err", 32'(bus.req_err), 32'd0);
    chk("hold.no_ack", 32'(bus.req_ack), 32'd0);
    bus.m_done = 1'b1;
    tick;
    bus.m_done = 1'b0;
    tick;
    chk("hold.req_ack", 32'(bus.req_ack), 32'b0001);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
